// File: rtl/fu_branch_resolve.sv
// fu_branch_resolve
// Consumer end of the branch FU result path. Acknowledges resolved branches,
// detects mispredicts against the fetch-time prediction, raises a one-shot
// fetch redirect, counts mispredicts, and buffers every result in a small
// FIFO that drains onto the CDB.
//
// Handshakes:
//   FU side : fu_ack is the combinational consume strobe. A result is taken
//             in the cycle where fu_result_valid && fu_ack; the FU must hold
//             a refused result (fu_ack=0) or drop it on squash.
//   CDB side: strict valid/ready. cdb_valid never depends on cdb_ready; the
//             head entry transfers on a clock edge where cdb_valid &&
//             cdb_ready, and cdb_* stay stable while cdb_valid && !cdb_ready.
module fu_branch_resolve #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             fu_result_valid,
    input  logic             fu_take_branch,
    input  logic [XLEN-1:0]  fu_alu_result,
    input  logic [XLEN-1:0]  fu_npc,
    input  logic [4:0]       fu_dest_reg_idx,
    input  logic             fu_pred_taken,
    input  logic [XLEN-1:0]  fu_pred_target,
    output logic             fu_ack,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [4:0]       cdb_dest_reg_idx,
    output logic [XLEN-1:0]  cdb_value,
    output logic             cdb_mispredict,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_RUN         = 1'b0,
        ST_WAIT_SQUASH = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // FIFO storage and bookkeeping
    logic [4:0]       mem_dest  [DEPTH];
    logic [XLEN-1:0]  mem_value [DEPTH];
    logic             mem_mis   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;

    logic             push;
    logic             pop;
    logic             fifo_blocked;
    logic             is_mispredict;
    logic [XLEN-1:0]  correct_pc;

    // Mispredict detection and the PC fetch should have used
    always_comb begin
        is_mispredict = (fu_take_branch != fu_pred_taken) ||
                        (fu_take_branch && (fu_alu_result != fu_pred_target));
        correct_pc    = fu_take_branch ? fu_alu_result : fu_npc;
    end

    // Acknowledge and FIFO push/pop strobes; a full FIFO still accepts when
    // its head leaves in the same cycle
    always_comb begin
        cdb_valid    = (occ_q != '0);
        pop          = cdb_valid && cdb_ready;
        fifo_blocked = (occ_q == OCC_W'(DEPTH)) && !pop;
        fu_ack       = fu_result_valid && !fifo_blocked &&
                       (state_q == ST_RUN) && !squash && !reset;
        push         = fu_ack;
    end

    // Present the head entry; zero while nothing is buffered
    always_comb begin
        cdb_dest_reg_idx = '0;
        cdb_value        = '0;
        cdb_mispredict   = 1'b0;
        if (cdb_valid) begin
            cdb_dest_reg_idx = mem_dest[rd_ptr_q];
            cdb_value        = mem_value[rd_ptr_q];
            cdb_mispredict   = mem_mis[rd_ptr_q];
        end
    end

    // Next state: an acked mispredict parks the unit until the ROB flushes
    always_comb begin
        state_d = state_q;
        if (squash) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && fu_ack && is_mispredict) begin
            state_d = ST_WAIT_SQUASH;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    // FIFO payload write; contents are don't-care until pointed at by occ_q
    always_ff @(posedge clock) begin
        if (push) begin
            mem_dest[wr_ptr_q]  <= fu_dest_reg_idx;
            mem_value[wr_ptr_q] <= fu_npc;
            mem_mis[wr_ptr_q]   <= is_mispredict;
        end
    end

    // FIFO pointers and occupancy; squash empties the queue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (squash) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    // One-cycle redirect pulse with the corrected PC held afterwards
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (squash) begin
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= fu_ack && is_mispredict;
            if (fu_ack && is_mispredict) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    // Saturating mispredict counter, survives squash
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mispredict_cnt <= '0;
        end else if (fu_ack && is_mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fu_branch_resolve.sv
// tb_fu_branch_resolve
// Directed scenarios for fu_branch_resolve with a 2-bit mispredict counter.
module tb_fu_branch_resolve;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clock;
    logic             reset;
    logic             squash;
    logic             fu_result_valid;
    logic             fu_take_branch;
    logic [XLEN-1:0]  fu_alu_result;
    logic [XLEN-1:0]  fu_npc;
    logic [4:0]       fu_dest_reg_idx;
    logic             fu_pred_taken;
    logic [XLEN-1:0]  fu_pred_target;
    logic             fu_ack;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [4:0]       cdb_dest_reg_idx;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_mispredict;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;
    logic             dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q[$];

    fu_branch_resolve #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .fu_result_valid  (fu_result_valid),
        .fu_take_branch   (fu_take_branch),
        .fu_alu_result    (fu_alu_result),
        .fu_npc           (fu_npc),
        .fu_dest_reg_idx  (fu_dest_reg_idx),
        .fu_pred_taken    (fu_pred_taken),
        .fu_pred_target   (fu_pred_target),
        .fu_ack           (fu_ack),
        .cdb_valid        (cdb_valid),
        .cdb_ready        (cdb_ready),
        .cdb_dest_reg_idx (cdb_dest_reg_idx),
        .cdb_value        (cdb_value),
        .cdb_mispredict   (cdb_mispredict),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mispredict_cnt   (mispredict_cnt),
        .dbg_state        (dbg_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic take, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] npc, input logic [4:0] dest,
                         input logic ptaken, input logic [XLEN-1:0] ptgt);
        fu_result_valid = 1'b1;
        fu_take_branch  = take;
        fu_alu_result   = alu;
        fu_npc          = npc;
        fu_dest_reg_idx = dest;
        fu_pred_taken   = ptaken;
        fu_pred_target  = ptgt;
    endtask

    task automatic idle();
        fu_result_valid = 1'b0;
        fu_take_branch  = 1'b0;
        fu_alu_result   = '0;
        fu_npc          = '0;
        fu_dest_reg_idx = '0;
        fu_pred_taken   = 1'b0;
        fu_pred_target  = '0;
    endtask

    task automatic do_reset();
        idle();
        squash    = 1'b0;
        cdb_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // Pending result while reset is high must not be acknowledged
        drive(1'b1, 32'h40, 32'h44, 5'd3, 1'b0, 32'h0);
        #1;
        n_checks++; if (fu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%0b exp=0", fu_ack); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid got=%0b exp=0", cdb_valid); end
        n_checks++; if (cdb_value !== 32'h0) begin n_fail++; $display("FAIL reset_cdb_value got=%h exp=0", cdb_value); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%0b exp=0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        n_checks++; if (mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", mispredict_cnt); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
        idle();
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_empty got=%0b exp=0", cdb_valid); end
    endtask

    task automatic test_correct_not_taken();
        do_reset();
        drive(1'b0, 32'h500, 32'h104, 5'd0, 1'b0, 32'h999);
        #1;
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL nt_ack got=%0b exp=1", fu_ack); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL nt_no_bypass got=%0b exp=0", cdb_valid); end
        tick();
        idle();
        n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL nt_cdb_valid got=%0b exp=1", cdb_valid); end
        n_checks++; if (cdb_value !== 32'h104) begin n_fail++; $display("FAIL nt_cdb_value got=%h exp=104", cdb_value); end
        n_checks++; if (cdb_mispredict !== 1'b0) begin n_fail++; $display("FAIL nt_cdb_mis got=%0b exp=0", cdb_mispredict); end
        n_checks++; if (cdb_dest_reg_idx !== 5'd0) begin n_fail++; $display("FAIL nt_cdb_dest got=%0d exp=0", cdb_dest_reg_idx); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL nt_redirect got=%0b exp=0", redirect_valid); end
        n_checks++; if (mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL nt_cnt got=%0d exp=0", mispredict_cnt); end
        cdb_ready = 1'b1;
        tick();
        cdb_ready = 1'b0;
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL nt_drained got=%0b exp=0", cdb_valid); end
    endtask

    task automatic test_wrong_target();
        do_reset();
        drive(1'b1, 32'h240, 32'h104, 5'd1, 1'b1, 32'h200);
        #1;
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL wt_ack got=%0b exp=1", fu_ack); end
        tick();
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wt_redirect got=%0b exp=1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h240) begin n_fail++; $display("FAIL wt_redirect_pc got=%h exp=240", redirect_pc); end
        n_checks++; if (mispredict_cnt !== 2'd1) begin n_fail++; $display("FAIL wt_cnt got=%0d exp=1", mispredict_cnt); end
        n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL wt_state got=%0b exp=1", dbg_state); end
        n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL wt_cdb_valid got=%0b exp=1", cdb_valid); end
        n_checks++; if (cdb_value !== 32'h104) begin n_fail++; $display("FAIL wt_cdb_value got=%h exp=104", cdb_value); end
        n_checks++; if (cdb_mispredict !== 1'b1) begin n_fail++; $display("FAIL wt_cdb_mis got=%0b exp=1", cdb_mispredict); end
        n_checks++; if (cdb_dest_reg_idx !== 5'd1) begin n_fail++; $display("FAIL wt_cdb_dest got=%0d exp=1", cdb_dest_reg_idx); end
        // Younger wrong-path result must be refused
        drive(1'b0, 32'h0, 32'h108, 5'd2, 1'b0, 32'h0);
        #1;
        n_checks++; if (fu_ack !== 1'b0) begin n_fail++; $display("FAIL wt_refuse got=%0b exp=0", fu_ack); end
        tick();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wt_one_shot got=%0b exp=0", redirect_valid); end
        n_checks++; if (mispredict_cnt !== 2'd1) begin n_fail++; $display("FAIL wt_cnt_hold got=%0d exp=1", mispredict_cnt); end
        // FIFO still drains while waiting for the flush
        cdb_ready = 1'b1;
        tick();
        cdb_ready = 1'b0;
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL wt_drain got=%0b exp=0", cdb_valid); end
        n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL wt_still_wait got=%0b exp=1", dbg_state); end
        squash = 1'b1;
        #1;
        n_checks++; if (fu_ack !== 1'b0) begin n_fail++; $display("FAIL wt_squash_ack got=%0b exp=0", fu_ack); end
        tick();
        squash = 1'b0;
        #1;
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL wt_back_run got=%0b exp=0", dbg_state); end
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL wt_ack_after got=%0b exp=1", fu_ack); end
        idle();
    endtask

    task automatic test_direction_miss();
        do_reset();
        drive(1'b0, 32'h400, 32'h308, 5'd4, 1'b1, 32'h400);
        #1;
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL dm_ack got=%0b exp=1", fu_ack); end
        tick();
        idle();
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL dm_redirect got=%0b exp=1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h308) begin n_fail++; $display("FAIL dm_redirect_pc got=%h exp=308", redirect_pc); end
        n_checks++; if (cdb_value !== 32'h308) begin n_fail++; $display("FAIL dm_cdb_value got=%h exp=308", cdb_value); end
        n_checks++; if (cdb_mispredict !== 1'b1) begin n_fail++; $display("FAIL dm_cdb_mis got=%0b exp=1", cdb_mispredict); end
        squash = 1'b1;
        tick();
        squash = 1'b0;
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL dm_state got=%0b exp=0", dbg_state); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL dm_fifo_empty got=%0b exp=0", cdb_valid); end
        n_checks++; if (mispredict_cnt !== 2'd1) begin n_fail++; $display("FAIL dm_cnt_kept got=%0d exp=1", mispredict_cnt); end
        drive(1'b0, 32'h0, 32'h30c, 5'd0, 1'b0, 32'h0);
        #1;
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL dm_next_ack got=%0b exp=1", fu_ack); end
        idle();
    endtask

    task automatic test_full_fifo();
        logic [XLEN-1:0] npcs [3];
        logic            exp_ack [3];
        npcs[0] = 32'h10; npcs[1] = 32'h20; npcs[2] = 32'h30;
        exp_ack[0] = 1'b1; exp_ack[1] = 1'b1; exp_ack[2] = 1'b0;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, npcs[i], 5'd5, 1'b0, 32'h0);
            #1;
            n_checks++; if (fu_ack !== exp_ack[i]) begin n_fail++; $display("FAIL full_ack%0d got=%0b exp=%0b", i, fu_ack, exp_ack[i]); end
            if (exp_ack[i]) exp_q.push_back(npcs[i]);
            tick();
        end
        // Full: a new result is accepted only because the head leaves too
        drive(1'b0, 32'h0, 32'h40, 5'd5, 1'b0, 32'h0);
        cdb_ready = 1'b1;
        #1;
        n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ack got=%0b exp=1", fu_ack); end
        n_checks++; if (cdb_value !== exp_q[0]) begin n_fail++; $display("FAIL full_head got=%h exp=%h", cdb_value, exp_q[0]); end
        exp_q.push_back(32'h40);
        tick();
        idle();
        void'(exp_q.pop_front());
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (exp_q.size() != 0) begin
                n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain_valid%0d got=%0b exp=1", i, cdb_valid); end
                n_checks++; if (cdb_value !== exp_q[0]) begin n_fail++; $display("FAIL full_drain_value%0d got=%h exp=%h", i, cdb_value, exp_q[0]); end
                tick();
                void'(exp_q.pop_front());
            end
        end
        cdb_ready = 1'b0;
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0b exp=0", cdb_valid); end
    endtask

    task automatic test_squash_with_mispredict();
        do_reset();
        drive(1'b0, 32'h0, 32'h50, 5'd6, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h700, 32'h54, 5'd7, 1'b0, 32'h0);
        squash = 1'b1;
        #1;
        n_checks++; if (fu_ack !== 1'b0) begin n_fail++; $display("FAIL sq_ack got=%0b exp=0", fu_ack); end
        tick();
        squash = 1'b0;
        idle();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sq_redirect got=%0b exp=0", redirect_valid); end
        n_checks++; if (mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL sq_cnt got=%0d exp=0", mispredict_cnt); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL sq_fifo_empty got=%0b exp=0", cdb_valid); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL sq_state got=%0b exp=0", dbg_state); end
    endtask

    task automatic test_counter_saturation();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 32'h20 + 32'(i * 4), 5'd8, 1'b0, 32'h0);
            #1;
            n_checks++; if (fu_ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack%0d got=%0b exp=1", i, fu_ack); end
            tick();
            idle();
            n_checks++; if (mispredict_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, mispredict_cnt, exp_cnt[i]); end
            squash = 1'b1;
            tick();
            squash = 1'b0;
        end
        n_checks++; if (mispredict_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_final got=%0d exp=3", mispredict_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'h880, 32'h84, 5'd9, 1'b0, 32'h0);
        tick();
        // Busy state: FIFO holds an entry, redirect is pulsing, state is parked
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_redirect got=%0b exp=1", redirect_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (fu_ack !== 1'b0) begin n_fail++; $display("FAIL ar_ack got=%0b exp=0", fu_ack); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL ar_cdb_valid got=%0b exp=0", cdb_valid); end
        n_checks++; if (cdb_value !== 32'h0) begin n_fail++; $display("FAIL ar_cdb_value got=%h exp=0", cdb_value); end
        n_checks++; if (cdb_mispredict !== 1'b0) begin n_fail++; $display("FAIL ar_cdb_mis got=%0b exp=0", cdb_mispredict); end
        n_checks++; if (cdb_dest_reg_idx !== 5'd0) begin n_fail++; $display("FAIL ar_cdb_dest got=%0d exp=0", cdb_dest_reg_idx); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ar_redirect got=%0b exp=0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL ar_redirect_pc got=%h exp=0", redirect_pc); end
        n_checks++; if (mispredict_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_cnt got=%0d exp=0", mispredict_cnt); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL ar_state got=%0b exp=0", dbg_state); end
        idle();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Scenario sequence and final report
    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_ready = 1'b0;
        idle();
        test_reset();
        test_correct_not_taken();
        test_wrong_target();
        test_direction_miss();
        test_full_fifo();
        test_squash_with_mispredict();
        test_counter_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
